// File: rtl/demod_mc.sv
// demod_mc -- multi-channel FM demodulator stage.
// Per channel: conjugate product of the current and previous sample, then a
// quantized arctangent driven by a sequential restoring divider, then a fixed
// gain, with the result pushed to the downstream FIFO.
// Build option: define DEMOD_SAT_EN to saturate the result to the signed
// DATA_W range; when undefined the low DATA_W bits are kept (wrap).
module demod_mc #(
   parameter int DATA_W      = 32,
   parameter int FRAC_BITS   = 10,
   parameter int NUM_CH      = 2,
   parameter int GAIN        = 32'h2F6,
   parameter int PRIME_VALUE = 32'h4A6,
   parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              input_fifos_empty,
   output logic              input_rd_en,
   input  logic [DATA_W-1:0] real_in,
   input  logic [DATA_W-1:0] imag_in,
   input  logic [CH_W-1:0]   chan_in,
   output logic [DATA_W-1:0] demod_out,
   output logic [CH_W-1:0]   chan_out,
   output logic              wr_en_out,
   input  logic              out_fifo_full,
   output logic              busy
);

   localparam int W2    = 2 * DATA_W;
   localparam int CNT_W = $clog2(W2);
   // round(pi/4 * 2^FRAC_BITS) in integer arithmetic
   localparam longint Q1_L = ((longint'(1) << FRAC_BITS) * 64'sd785398163
                              + 64'sd500000000) / 64'sd1000000000;
   localparam logic signed [W2-1:0] Q1_X   = W2'(Q1_L);
   localparam logic signed [W2-1:0] Q3_X   = W2'(3 * Q1_L);
   localparam logic signed [W2-1:0] GAIN_X = W2'(GAIN);
`ifdef DEMOD_SAT_EN
   localparam logic signed [W2-1:0] SAT_MAX = {{(W2-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [W2-1:0] SAT_MIN = {{(W2-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

   typedef enum logic [2:0] {IDLE, MULT, DIV, SCALE, OUTPUT} state_t;

   state_t state, state_nxt;

   logic signed [DATA_W-1:0] hist_re [NUM_CH];
   logic signed [DATA_W-1:0] hist_im [NUM_CH];
   logic [NUM_CH-1:0]        hist_vld;
   logic signed [DATA_W-1:0] cur_re, cur_im;
   logic [CH_W-1:0]          cur_chan;
   logic signed [W2-1:0]     sr_q, si_q;
   logic [W2-1:0]            dvd, dv, rem;
   logic                     q_neg;
   logic [CNT_W-1:0]         cnt;

   logic                     ch_ok;
   logic signed [W2-1:0]     pr, pim, cr, ci, sr_c, si_c, ay, num, den;
   logic [W2-1:0]            num_mag, den_mag;
   logic [W2:0]              trial, diff;
   logic signed [W2-1:0]     quo, ang;
   logic [DATA_W-1:0]        res_out;
`ifdef DEMOD_SAT_EN
   logic signed [W2-1:0]     res_full;
`endif

   // Signed divide by 2^FRAC_BITS truncating toward zero (bias negatives first).
   function automatic logic signed [W2-1:0] dq(input logic signed [W2-1:0] v);
      logic signed [W2-1:0] bias;
      bias = v[W2-1] ? W2'((1 << FRAC_BITS) - 1) : '0;
      return (v + bias) >>> FRAC_BITS;
   endfunction

   assign ch_ok = (32'(chan_in) < 32'(NUM_CH));
   assign busy  = (state != IDLE);

   // Conjugate product and divider operand setup from latched sample and history.
   always_comb begin
      pr   = W2'(hist_re[cur_chan]);
      pim  = W2'(hist_im[cur_chan]);
      cr   = W2'(cur_re);
      ci   = W2'(cur_im);
      sr_c = dq(pr * cr) - dq(-pim * ci);
      si_c = dq(pr * ci) + dq(-pim * cr);
      ay   = (si_c[W2-1] ? -si_c : si_c) + W2'(1);
      if (!sr_c[W2-1]) begin
         num = (sr_c - ay) <<< FRAC_BITS;
         den = sr_c + ay;
      end else begin
         num = (sr_c + ay) <<< FRAC_BITS;
         den = ay - sr_c;
      end
      num_mag = num[W2-1] ? -num : num;
      den_mag = den[W2-1] ? -den : den;
   end

   // One restoring-division step: borrow out of diff means the trial did not fit.
   always_comb begin
      trial = {rem, dvd[W2-1]};
      diff  = trial - {1'b0, dv};
   end

   // Angle reconstruction, gain and reduction to DATA_W.
   always_comb begin
      quo = q_neg ? -$signed(dvd) : $signed(dvd);
      ang = (sr_q[W2-1] ? Q3_X : Q1_X) - dq(Q1_X * quo);
      if (si_q[W2-1])
         ang = -ang;
`ifdef DEMOD_SAT_EN
      res_full = dq(ang * GAIN_X);
      if (res_full > SAT_MAX)
         res_out = {1'b0, {(DATA_W-1){1'b1}}};
      else if (res_full < SAT_MIN)
         res_out = {1'b1, {(DATA_W-1){1'b0}}};
      else
         res_out = res_full[DATA_W-1:0];
`else
      res_out = DATA_W'(dq(ang * GAIN_X));
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and FIFO handshakes.
   always_comb begin
      state_nxt   = state;
      input_rd_en = 1'b0;
      wr_en_out   = 1'b0;
      case (state)
         IDLE: begin
            if (!input_fifos_empty) begin
               input_rd_en = 1'b1;
               if (!ch_ok)
                  state_nxt = IDLE;
               else if (!hist_vld[chan_in])
                  state_nxt = OUTPUT;
               else
                  state_nxt = MULT;
            end
         end
         MULT:  state_nxt = DIV;
         DIV:   if (cnt == CNT_W'(W2 - 1)) state_nxt = SCALE;
         SCALE: state_nxt = OUTPUT;
         OUTPUT: begin
            if (!out_fifo_full) begin
               wr_en_out = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: history file, divider registers and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            hist_re[i] <= '0;
            hist_im[i] <= '0;
         end
         hist_vld  <= '0;
         cur_re    <= '0;
         cur_im    <= '0;
         cur_chan  <= '0;
         sr_q      <= '0;
         si_q      <= '0;
         dvd       <= '0;
         dv        <= '0;
         rem       <= '0;
         q_neg     <= 1'b0;
         cnt       <= '0;
         demod_out <= '0;
         chan_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!input_fifos_empty && ch_ok) begin
                  if (!hist_vld[chan_in]) begin
                     hist_re[chan_in]  <= real_in;
                     hist_im[chan_in]  <= imag_in;
                     hist_vld[chan_in] <= 1'b1;
                     demod_out         <= DATA_W'(PRIME_VALUE);
                     chan_out          <= chan_in;
                  end else begin
                     cur_re   <= real_in;
                     cur_im   <= imag_in;
                     cur_chan <= chan_in;
                  end
               end
            end
            MULT: begin
               hist_re[cur_chan] <= cur_re;
               hist_im[cur_chan] <= cur_im;
               sr_q  <= sr_c;
               si_q  <= si_c;
               dvd   <= num_mag;
               dv    <= den_mag;
               rem   <= '0;
               q_neg <= num[W2-1] ^ den[W2-1];
               cnt   <= '0;
            end
            DIV: begin
               dvd <= {dvd[W2-2:0], ~diff[W2]};
               rem <= diff[W2] ? trial[W2-1:0] : diff[W2-1:0];
               cnt <= cnt + 1'b1;
            end
            SCALE: begin
               demod_out <= res_out;
               chan_out  <= cur_chan;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/demod_mc.md
# demod_mc

Multi-channel, parametrised FM demodulator stage. It consumes interleaved complex baseband samples tagged with a channel index. For each channel it computes the phase difference between the current sample and that channel's previous sample: a conjugate product, then a quantized arctangent using an internal sequential divider. It scales the result by a fixed gain and writes the demodulated value to the downstream FIFO. It sits between the channel-select/decimation FIFOs and the audio filter FIFOs.

## Interface
- DATA_W, 32, signed sample and output width
- FRAC_BITS, 10, fixed-point fraction bits used by quantize/dequantize
- NUM_CH, 2, number of interleaved channels (1..16)
- GAIN, 32'h2F6, demodulation gain (quantized)
- PRIME_VALUE, 32'h4A6, value emitted for the first sample of each channel
- CH_W, max(1,$clog2(NUM_CH)), derived channel-index width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- input_fifos_empty  in  1  real/imag/chan input FIFOs empty
- input_rd_en  out  1  pops one sample from all input FIFOs
- real_in, imag_in  in  DATA_W  signed sample
- chan_in  in  CH_W  channel index of the sample
- demod_out  out  DATA_W  demodulated value
- chan_out  out  CH_W  channel of demod_out
- wr_en_out  out  1  push to output FIFO
- out_fifo_full  in  1  output FIFO full
- busy  out  1  sample in flight (state != IDLE)

## Operation
- One sample in flight; per-channel register file holds prev real/imag plus a valid bit.
- States:
  - IDLE: if !input_fifos_empty, assert input_rd_en and latch the sample.
    - chan_in >= NUM_CH: drop the sample, stay in IDLE, no history change.
    - Channel valid bit = 0: store the sample as history, set valid, load PRIME_VALUE, go to OUTPUT.
    - Otherwise go to MULT.
  - MULT:
    - short_real = DQ(pr*cr) - DQ(-pi*ci)
    - short_imag = DQ(pr*ci) + DQ(-pi*cr)
    - Arithmetic is 2*DATA_W signed.
    - Write the current sample into history.
    - Go to DIV.
  - DIV: restoring signed divide, 2*DATA_W iterations, truncation toward zero.
    - ay = |short_imag| + 1.
    - If x >= 0: r = ((x - ay) << FRAC_BITS) / (x + ay).
    - Else: r = ((x + ay) << FRAC_BITS) / (ay - x).
    - The denominator is never 0.
  - SCALE:
    - angle = Q1 - DQ(Q1*r) for x >= 0, else Q3 - DQ(Q1*r).
    - Q1 = round(pi/4 * 2^FRAC_BITS); Q3 = 3*Q1.
    - Negate angle if short_imag < 0.
    - result = DQ(angle*GAIN), reduced to DATA_W per Configuration.
    - Go to OUTPUT.
  - OUTPUT: when !out_fifo_full, assert wr_en_out for one cycle and go to IDLE; otherwise hold.
- DQ(v) = signed division by 2^FRAC_BITS, truncating toward zero (not an arithmetic shift).
- demod_out and chan_out are registered and stable from entering OUTPUT until the next result is loaded.

## Timing
- Reset: state IDLE; history and valid bits cleared; demod_out 0, chan_out 0, wr_en_out 0, input_rd_en 0, busy 0.
- input_rd_en and wr_en_out are combinational from state and FIFO flags, and are never asserted in the same cycle.
- Prime path: read in cycle 0; wr_en_out earliest in cycle 1.
- Compute path: read in cycle 0, MULT in cycle 1, DIV in cycles 2..2*DATA_W+1, SCALE in cycle 2*DATA_W+2; wr_en_out earliest in cycle 2*DATA_W+3 (67 for DATA_W=32).
- Back-to-back throughput: one sample per (latency + 1) cycles. The next read happens in the cycle after wr_en_out.
- out_fifo_full held: stall in OUTPUT indefinitely; no reads, no data loss.
- Reset asserted mid-operation: the in-flight sample is discarded, no write occurs, and every channel re-primes.

## Configuration
- DEMOD_SAT_EN defined: result is saturated to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: result is the low DATA_W bits of the 2*DATA_W value (wrap).

## Test plan
- Reset release, empty input: all outputs 0, input_rd_en never asserted.
- Ch0 sample (1024,0), first of channel: demod_out = 0x4A6, chan_out = 0, wr_en_out at cycle 1.
- Ch0 (1024,0) then (1024,0): r = 1022, angle = 2, demod_out = 1. Then (0,1024): angle = 1608, demod_out = 0x4A6 (1190), at cycle 67 after the read.
- Interleave ch0 (1024,0), ch1 (0,1024), ch0 (0,1024), ch1 (0,1024): outputs 0x4A6/ch0, 0x4A6/ch1, 0x4A6/ch0, then 1/ch1. Channel histories must stay independent.
- out_fifo_full held 5 cycles during OUTPUT: wr_en_out delayed 5 cycles, demod_out stable, no input_rd_en. chan_in = NUM_CH is consumed with no output. Reset pulsed in DIV: no write, next sample re-primes.
- DATA_W = 12, ch0 (1024,0) then (-1024,0): angle = 3214, raw result 2379. With DEMOD_SAT_EN: 0x7FF. Without: 0x94B.
